// File: rtl/sdc_pkg.sv
// Shared definitions for the SPI-mode SD card command path.
// Frame layout, FSM encoding and the standard command indices.
package sdc_pkg;

   localparam int unsigned FRAME_W = 48;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [1:0] START_BITS = 2'b01;
   localparam logic       STOP_BIT   = 1'b1;
   localparam logic [7:0] IDLE_BYTE  = 8'hFF;

   localparam logic [5:0] CMD0   = 6'd0;
   localparam logic [5:0] CMD8   = 6'd8;
   localparam logic [5:0] CMD55  = 6'd55;
   localparam logic [5:0] ACMD41 = 6'd41;
   localparam logic [5:0] CMD58  = 6'd58;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_CMD,
      ST_RESP,
      ST_POST,
      ST_FIN
   } sdc_state_t;

   typedef struct packed {
      logic [1:0]  start;
      logic [5:0]  cmd;
      logic [31:0] arg;
      logic [6:0]  crc;
      logic        stop;
   } sdc_frame_t;

   // Assemble the 48-bit command frame, MSB is transmitted first.
   function automatic sdc_frame_t sdc_build_frame(input logic [5:0]  cmd,
                                                  input logic [31:0] arg,
                                                  input logic [6:0]  crc);
      sdc_frame_t f;
      f.start = START_BITS;
      f.cmd   = cmd;
      f.arg   = arg;
      f.crc   = crc;
      f.stop  = STOP_BIT;
      return f;
   endfunction

endpackage

// File: rtl/sdc_spi_clkgen.sv
// SPI mode-0 clock divider: SCK toggles every DIV system clocks while enabled.
// Rise/fall strobes mark the system-clock edge on which SCK changes.
module sdc_spi_clkgen #(
   parameter int unsigned DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_sck,
   output logic o_rise_c,
   output logic o_fall_c
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_sck;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(DIV - 1));

   // Phase counter and SCK; both forced to zero whenever the link is idle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_sck <= 1'b0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_sck <= 1'b0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_sck <= ~r_sck;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_sck    = r_sck;
   assign o_rise_c = i_en && w_wrap && !r_sck;
   assign o_fall_c = i_en && w_wrap &&  r_sck;

endmodule

// File: rtl/sdc_cmd_tx.sv
// SPI-mode SD command engine: sends one 48-bit command frame after 8 idle clocks,
// polls MISO byte-wise for R1, then adds 8 release clocks before reporting.
module sdc_cmd_tx
   import sdc_pkg::*;
#(
   parameter int unsigned DIV     = 2,
   parameter int unsigned NCR_MAX = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [5:0]  i_cmd,
   input  logic [31:0] i_arg,
   input  logic [6:0]  i_crc,
   input  logic        i_miso,
   output logic        o_sck,
   output logic        o_mosi,
   output logic        o_cs,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_resp,
   output logic        o_timeout
);

   localparam int unsigned BIT_CW  = 6;
   localparam int unsigned BYTE_CW = 4;

   sdc_state_t          r_state, w_state_nxt;
   logic [FRAME_W-1:0]  r_shift, w_shift_nxt;
   logic [BIT_CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic [BYTE_CW-1:0]  r_byte_cnt, w_byte_cnt_nxt;
   logic [BYTE_W-1:0]   r_rx, w_rx_nxt;
   logic [BYTE_W-1:0]   r_resp, w_resp_nxt;
   logic                r_mosi, w_mosi_nxt;
   logic                r_cs, w_cs_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic                r_timeout, w_timeout_nxt;

   logic w_sck_en;
   logic w_rise;
   logic w_fall;

   assign w_sck_en = (r_state == ST_PRE) || (r_state == ST_CMD) ||
                     (r_state == ST_RESP) || (r_state == ST_POST);

   sdc_spi_clkgen #(
      .DIV (DIV)
   ) u_clkgen (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (w_sck_en),
      .o_sck    (o_sck),
      .o_rise_c (w_rise),
      .o_fall_c (w_fall)
   );

   // State and datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_rx       <= '0;
         r_resp     <= IDLE_BYTE;
         r_mosi     <= 1'b1;
         r_cs       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_rx       <= w_rx_nxt;
         r_resp     <= w_resp_nxt;
         r_mosi     <= w_mosi_nxt;
         r_cs       <= w_cs_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   // Next-state and next-output logic; bits advance on SCK falling strobes.
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_byte_cnt_nxt = r_byte_cnt;
      w_rx_nxt       = r_rx;
      w_resp_nxt     = r_resp;
      w_mosi_nxt     = r_mosi;
      w_cs_nxt       = r_cs;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_timeout_nxt  = r_timeout;

      unique case (r_state)
         ST_IDLE: begin
            w_mosi_nxt = 1'b1;
            w_cs_nxt   = 1'b1;
            if (i_start) begin
               w_state_nxt    = ST_PRE;
               w_shift_nxt    = sdc_build_frame(i_cmd, i_arg, i_crc);
               w_bit_cnt_nxt  = '0;
               w_byte_cnt_nxt = '0;
               w_rx_nxt       = IDLE_BYTE;
               w_resp_nxt     = IDLE_BYTE;
               w_timeout_nxt  = 1'b0;
               w_cs_nxt       = 1'b0;
               w_busy_nxt     = 1'b1;
            end
         end

         ST_PRE: begin
            if (w_fall) begin
               if (r_bit_cnt == BIT_CW'(BYTE_W - 1)) begin
                  w_state_nxt   = ST_CMD;
                  w_bit_cnt_nxt = '0;
                  w_mosi_nxt    = r_shift[FRAME_W-1];
                  w_shift_nxt   = {r_shift[FRAME_W-2:0], 1'b0};
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_CW'(1);
               end
            end
         end

         ST_CMD: begin
            if (w_fall) begin
               if (r_bit_cnt == BIT_CW'(FRAME_W - 1)) begin
                  w_state_nxt   = ST_RESP;
                  w_bit_cnt_nxt = '0;
                  w_mosi_nxt    = 1'b1;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_CW'(1);
                  w_mosi_nxt    = r_shift[FRAME_W-1];
                  w_shift_nxt   = {r_shift[FRAME_W-2:0], 1'b0};
               end
            end
         end

         // The eighth bit is sampled on the rise; the byte is judged on the following fall.
         ST_RESP: begin
            w_mosi_nxt = 1'b1;
            if (w_rise) begin
               w_rx_nxt = {r_rx[BYTE_W-2:0], i_miso};
            end
            if (w_fall) begin
               if (r_bit_cnt == BIT_CW'(BYTE_W - 1)) begin
                  w_bit_cnt_nxt  = '0;
                  w_byte_cnt_nxt = r_byte_cnt + BYTE_CW'(1);
                  if (!r_rx[BYTE_W-1]) begin
                     w_resp_nxt  = r_rx;
                     w_state_nxt = ST_POST;
                  end else if (r_byte_cnt == BYTE_CW'(NCR_MAX - 1)) begin
                     w_timeout_nxt = 1'b1;
                     w_resp_nxt    = IDLE_BYTE;
                     w_state_nxt   = ST_POST;
                  end
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_CW'(1);
               end
            end
         end

         // CS rises on the same edge that returns SCK low for the last time.
         ST_POST: begin
            w_mosi_nxt = 1'b1;
            if (w_fall) begin
               if (r_bit_cnt == BIT_CW'(BYTE_W - 1)) begin
                  w_state_nxt   = ST_FIN;
                  w_bit_cnt_nxt = '0;
                  w_cs_nxt      = 1'b1;
                  w_busy_nxt    = 1'b0;
                  w_done_nxt    = 1'b1;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_CW'(1);
               end
            end
         end

         ST_FIN: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_cs_nxt    = 1'b1;
            w_mosi_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign o_mosi    = r_mosi;
   assign o_cs      = r_cs;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_resp    = r_resp;
   assign o_timeout = r_timeout;

endmodule
